// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, field positions and widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int INSTR_W    = 32;
  localparam int NUM_REGS   = 32;

  localparam int OP_W     = 6;
  localparam int FUNCT_W  = 6;
  localparam int SHAMT_W  = 5;
  localparam int IMM_W    = 16;
  localparam int JIDX_W   = 26;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int JIDX_LSB  = 0;

  typedef enum logic [OP_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SB    = 6'h28,
    OP_SH    = 6'h29,
    OP_SW    = 6'h2B
  } opcode_e;

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [OP_W-1:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// Decode stage bus: IF/ID and write-back inputs, ID/EX outputs and stall to IF.
// Latency: n/a. Backpressure: o_stall holds IF/ID for one cycle per assertion.
interface id_stage_pipelined_if #(parameter int DATA_W = 32);
  import mips_pkg::*;

  logic [INSTR_W-1:0]    i_instr;
  logic [DATA_W-1:0]     i_pc_plus4;
  logic                  i_valid;
  logic                  i_flush;
  logic                  i_regwrite;
  logic [REG_ADDR_W-1:0] i_wb_addr;
  logic [DATA_W-1:0]     i_wb_data;
  logic                  i_ex_memread;
  logic [REG_ADDR_W-1:0] i_ex_rt_addr;

  logic                  o_stall;
  logic                  o_valid;
  logic [OP_W-1:0]       o_op;
  logic [FUNCT_W-1:0]    o_funct;
  logic [SHAMT_W-1:0]    o_shamt;
  logic [REG_ADDR_W-1:0] o_rs_addr;
  logic [REG_ADDR_W-1:0] o_rt_addr;
  logic [REG_ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0]     o_rs_reg;
  logic [DATA_W-1:0]     o_rt_reg;
  logic [DATA_W-1:0]     o_sig_extended;
  logic [DATA_W-1:0]     o_branch_addres;
  logic [DATA_W-1:0]     o_jump_dir;

  modport master (
    output i_instr, i_pc_plus4, i_valid, i_flush, i_regwrite, i_wb_addr,
           i_wb_data, i_ex_memread, i_ex_rt_addr,
    input  o_stall, o_valid, o_op, o_funct, o_shamt, o_rs_addr, o_rt_addr,
           o_rd_addr, o_rs_reg, o_rt_reg, o_sig_extended, o_branch_addres,
           o_jump_dir
  );

  modport slave (
    input  i_instr, i_pc_plus4, i_valid, i_flush, i_regwrite, i_wb_addr,
           i_wb_data, i_ex_memread, i_ex_rt_addr,
    output o_stall, o_valid, o_op, o_funct, o_shamt, o_rs_addr, o_rt_addr,
           o_rd_addr, o_rs_reg, o_rt_reg, o_sig_extended, o_branch_addres,
           o_jump_dir
  );

endinterface

// File: rtl/id_regfile.sv
// 32 x DATA_W register file, two combinational read ports, one write port, r0 hardwired 0.
// Latency: reads 0 cycles, writes land on the next edge.
// Backpressure: none.
module id_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Write-through only when enabled; r0 is forced to zero regardless of storage.
  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == '0)
      rdata_a = '0;
    else if ((RF_BYPASS != 0) && wr_en && (waddr == raddr_a))
      rdata_a = wdata;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (raddr_b == '0)
      rdata_b = '0;
    else if ((RF_BYPASS != 0) && wr_en && (waddr == raddr_b))
      rdata_b = wdata;
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS decode stage: regfile read, immediate/target generation, load-use stall, ID/EX register.
// Latency: 1 cycle instr -> ID/EX outputs; o_stall is combinational.
// Backpressure: load-use hazard raises o_stall and inserts a bubble; flush overrides stall.
module id_stage_pipelined
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_BYPASS = 1,
  parameter int HAZARD_EN = 1
) (
  input logic                 clk,
  input logic                 rst,
  id_stage_pipelined_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic [OP_W-1:0]       op;
    logic [FUNCT_W-1:0]    funct;
    logic [SHAMT_W-1:0]    shamt;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]     rs_reg;
    logic [DATA_W-1:0]     rt_reg;
    logic [DATA_W-1:0]     sig_ext;
    logic [DATA_W-1:0]     branch_tgt;
    logic [DATA_W-1:0]     jump_tgt;
  } idex_t;

  logic [OP_W-1:0]       op;
  logic [FUNCT_W-1:0]    funct;
  logic [SHAMT_W-1:0]    shamt;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [IMM_W-1:0]      imm;
  logic [JIDX_W-1:0]     jidx;
  logic [DATA_W-1:0]     rs_val;
  logic [DATA_W-1:0]     rt_val;
  logic [DATA_W-1:0]     imm_sext;
  logic [DATA_W-1:0]     sig_ext;
  logic                  hazard;
  logic                  stall;
  idex_t                 idex_d;
  idex_t                 idex_q;

  assign op      = bus.i_instr[OP_LSB    +: OP_W];
  assign rs_addr = bus.i_instr[RS_LSB    +: REG_ADDR_W];
  assign rt_addr = bus.i_instr[RT_LSB    +: REG_ADDR_W];
  assign rd_addr = bus.i_instr[RD_LSB    +: REG_ADDR_W];
  assign shamt   = bus.i_instr[SHAMT_LSB +: SHAMT_W];
  assign funct   = bus.i_instr[FUNCT_LSB +: FUNCT_W];
  assign imm     = bus.i_instr[IMM_LSB   +: IMM_W];
  assign jidx    = bus.i_instr[JIDX_LSB  +: JIDX_W];

  id_regfile #(
    .DATA_W    (DATA_W),
    .RF_BYPASS (RF_BYPASS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.i_regwrite),
    .waddr   (bus.i_wb_addr),
    .wdata   (bus.i_wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (rs_val),
    .rdata_b (rt_val)
  );

  assign imm_sext = DATA_W'($signed(imm));

  // LUI keeps bit 31 as sign so 64-bit builds see the canonical sign-extended value.
  always_comb begin
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: sig_ext = DATA_W'(imm);
      OP_LUI:                   sig_ext = DATA_W'($signed({imm, 16'h0000}));
      default:                  sig_ext = imm_sext;
    endcase
  end

  assign hazard = (HAZARD_EN != 0) && bus.i_valid && bus.i_ex_memread &&
                  (bus.i_ex_rt_addr != '0) &&
                  ((bus.i_ex_rt_addr == rs_addr) ||
                   ((bus.i_ex_rt_addr == rt_addr) && uses_rt(op)));

  assign stall       = hazard && !bus.i_flush && !rst;
  assign bus.o_stall = stall;

  always_comb begin
    idex_d = '0;
    if (!bus.i_flush && !stall) begin
      idex_d.valid      = bus.i_valid;
      idex_d.op         = op;
      idex_d.funct      = funct;
      idex_d.shamt      = shamt;
      idex_d.rs_addr    = rs_addr;
      idex_d.rt_addr    = rt_addr;
      idex_d.rd_addr    = rd_addr;
      idex_d.rs_reg     = rs_val;
      idex_d.rt_reg     = rt_val;
      idex_d.sig_ext    = sig_ext;
      idex_d.branch_tgt = bus.i_pc_plus4 + (imm_sext << 2);
      idex_d.jump_tgt   = {bus.i_pc_plus4[DATA_W-1:28], jidx, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign bus.o_valid         = idex_q.valid;
  assign bus.o_op            = idex_q.op;
  assign bus.o_funct         = idex_q.funct;
  assign bus.o_shamt         = idex_q.shamt;
  assign bus.o_rs_addr       = idex_q.rs_addr;
  assign bus.o_rt_addr       = idex_q.rt_addr;
  assign bus.o_rd_addr       = idex_q.rd_addr;
  assign bus.o_rs_reg        = idex_q.rs_reg;
  assign bus.o_rt_reg        = idex_q.rt_reg;
  assign bus.o_sig_extended  = idex_q.sig_ext;
  assign bus.o_branch_addres = idex_q.branch_tgt;
  assign bus.o_jump_dir      = idex_q.jump_tgt;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: a 32-bit write-through instance and a 64-bit read-old instance
// driven with identical stimulus, checked against a plain instruction-level reference model.
module tb_id_stage_pipelined;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        valid;
    logic        flush;
    logic        regwrite;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        memread;
    logic [4:0]  ex_rt;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [63:0] rs_reg;
    logic [63:0] rt_reg;
    logic [63:0] sext;
    logic [63:0] br;
    logic [63:0] jmp;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_pipelined_if #(.DATA_W(32)) bus32 ();
  id_stage_pipelined_if #(.DATA_W(64)) bus64 ();

  id_stage_pipelined #(.DATA_W(32), .RF_BYPASS(1), .HAZARD_EN(1)) dut32 (
    .clk (clk), .rst (rst), .bus (bus32)
  );
  id_stage_pipelined #(.DATA_W(64), .RF_BYPASS(0), .HAZARD_EN(1)) dut64 (
    .clk (clk), .rst (rst), .bus (bus64)
  );

  int checks   = 0;
  int failures = 0;

  out_t q32[$];
  out_t q64[$];
  bit   stall_q[$];
  logic [63:0] regs32 [32];
  logic [63:0] regs64 [32];
  bit   last_stall = 1'b0;

  logic [5:0]  ext_op  [6] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0F};
  logic [15:0] ext_imm [6] = '{16'hFFFC, 16'hFFFC, 16'hFFFC, 16'h8001, 16'h1234, 16'h8000};
  logic [5:0]  rnd_ops [14] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E,
                                6'h0F, 6'h23, 6'h2B, 6'h28, 6'h29, 6'h02, 6'h03};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_out(input string tag, input out_t g, input out_t e);
    chk({tag, ".valid"},  64'(g.valid),  64'(e.valid));
    chk({tag, ".op"},     64'(g.op),     64'(e.op));
    chk({tag, ".funct"},  64'(g.funct),  64'(e.funct));
    chk({tag, ".shamt"},  64'(g.shamt),  64'(e.shamt));
    chk({tag, ".rs"},     64'(g.rs),     64'(e.rs));
    chk({tag, ".rt"},     64'(g.rt),     64'(e.rt));
    chk({tag, ".rd"},     64'(g.rd),     64'(e.rd));
    chk({tag, ".rs_reg"}, g.rs_reg,      e.rs_reg);
    chk({tag, ".rt_reg"}, g.rt_reg,      e.rt_reg);
    chk({tag, ".sext"},   g.sext,        e.sext);
    chk({tag, ".branch"}, g.br,          e.br);
    chk({tag, ".jump"},   g.jmp,         e.jmp);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.instr = '0; s.pc = '0; s.valid = 0; s.flush = 0;
    s.regwrite = 0; s.wb_addr = '0; s.wb_data = '0; s.memread = 0; s.ex_rt = '0;
    return s;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rst      = ($urandom_range(0, 99) == 0);
    s.instr    = $urandom();
    s.instr[31:26] = rnd_ops[$urandom_range(0, 13)];
    s.instr[25:21] = 5'($urandom_range(0, 7));
    s.instr[20:16] = 5'($urandom_range(0, 7));
    s.pc       = {$urandom(), $urandom()};
    s.valid    = ($urandom_range(0, 9) != 0);
    s.flush    = ($urandom_range(0, 9) == 0);
    s.regwrite = $urandom_range(0, 1);
    s.wb_addr  = 5'($urandom_range(0, 7));
    s.wb_data  = {$urandom(), $urandom()};
    s.memread  = ($urandom_range(0, 9) < 3);
    s.ex_rt    = 5'($urandom_range(0, 7));
    return s;
  endfunction

  // Instruction-level reference: what ID/EX should hold after this cycle's edge.
  function automatic out_t model(input stim_t si, input int w, input bit byp,
                                 input logic [63:0] rf [32], output bit stall);
    stim_t s = si;
    logic [63:0] mask, sx;
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    bit          hz;
    out_t        o;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    s.pc      = s.pc & mask;
    s.wb_data = s.wb_data & mask;
    op  = s.instr[31:26];
    rs  = s.instr[25:21];
    rt  = s.instr[20:16];
    imm = s.instr[15:0];
    sx  = {{48{imm[15]}}, imm};
    hz  = s.valid && s.memread && (s.ex_rt != 0) &&
          ((s.ex_rt == rs) ||
           ((s.ex_rt == rt) && (op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B})));
    stall = hz && !s.flush && !s.rst;
    o = '0;
    if (s.rst || s.flush || stall) return o;
    o.valid = s.valid;
    o.op    = op;
    o.funct = s.instr[5:0];
    o.shamt = s.instr[10:6];
    o.rs    = rs;
    o.rt    = rt;
    o.rd    = s.instr[15:11];
    o.rs_reg = (rs == 0) ? 64'd0 :
               (byp && s.regwrite && s.wb_addr == rs) ? s.wb_data : rf[rs];
    o.rt_reg = (rt == 0) ? 64'd0 :
               (byp && s.regwrite && s.wb_addr == rt) ? s.wb_data : rf[rt];
    if (op inside {6'h0C, 6'h0D, 6'h0E}) o.sext = {48'd0, imm};
    else if (op == 6'h0F)                o.sext = {{32{imm[15]}}, imm, 16'h0000};
    else                                 o.sext = sx;
    o.sext = o.sext & mask;
    o.br   = (s.pc + sx * 4) & mask;
    o.jmp  = ((s.pc & ~64'h0FFF_FFFF) | {36'd0, s.instr[25:0], 2'b00}) & mask;
    return o;
  endfunction

  task automatic step(input stim_t s);
    out_t e32, e64;
    bit   st32, st64;
    @(posedge clk);
    #1;
    rst = s.rst;
    bus32.i_instr = s.instr;        bus64.i_instr = s.instr;
    bus32.i_pc_plus4 = s.pc[31:0];  bus64.i_pc_plus4 = s.pc;
    bus32.i_valid = s.valid;        bus64.i_valid = s.valid;
    bus32.i_flush = s.flush;        bus64.i_flush = s.flush;
    bus32.i_regwrite = s.regwrite;  bus64.i_regwrite = s.regwrite;
    bus32.i_wb_addr = s.wb_addr;    bus64.i_wb_addr = s.wb_addr;
    bus32.i_wb_data = s.wb_data[31:0]; bus64.i_wb_data = s.wb_data;
    bus32.i_ex_memread = s.memread; bus64.i_ex_memread = s.memread;
    bus32.i_ex_rt_addr = s.ex_rt;   bus64.i_ex_rt_addr = s.ex_rt;
    e32 = model(s, 32, 1'b1, regs32, st32);
    e64 = model(s, 64, 1'b0, regs64, st64);
    q32.push_back(e32);
    q64.push_back(e64);
    stall_q.push_back(st32);
    last_stall = st32;
    if (s.rst) begin
      for (int i = 0; i < 32; i++) begin regs32[i] = '0; regs64[i] = '0; end
    end else if (s.regwrite && s.wb_addr != 0) begin
      regs32[s.wb_addr] = {32'd0, s.wb_data[31:0]};
      regs64[s.wb_addr] = s.wb_data;
    end
  endtask

  // Monitor: o_stall is checked within its own cycle, ID/EX one edge after issue.
  initial begin : monitor
    out_t g;
    out_t e;
    bit   es;
    forever begin
      @(negedge clk);
      if (stall_q.size() > 0) begin
        es = stall_q.pop_front();
        chk("d32.stall", 64'(bus32.o_stall), 64'(es));
        chk("d64.stall", 64'(bus64.o_stall), 64'(es));
      end
      if (q32.size() >= 2) begin
        e = q32.pop_front();
        g = '0;
        g.valid = bus32.o_valid;     g.op = bus32.o_op;         g.funct = bus32.o_funct;
        g.shamt = bus32.o_shamt;     g.rs = bus32.o_rs_addr;    g.rt = bus32.o_rt_addr;
        g.rd = bus32.o_rd_addr;      g.rs_reg = 64'(bus32.o_rs_reg);
        g.rt_reg = 64'(bus32.o_rt_reg);  g.sext = 64'(bus32.o_sig_extended);
        g.br = 64'(bus32.o_branch_addres); g.jmp = 64'(bus32.o_jump_dir);
        cmp_out("d32", g, e);
      end
      if (q64.size() >= 2) begin
        e = q64.pop_front();
        g = '0;
        g.valid = bus64.o_valid;     g.op = bus64.o_op;         g.funct = bus64.o_funct;
        g.shamt = bus64.o_shamt;     g.rs = bus64.o_rs_addr;    g.rt = bus64.o_rt_addr;
        g.rd = bus64.o_rd_addr;      g.rs_reg = bus64.o_rs_reg;
        g.rt_reg = bus64.o_rt_reg;   g.sext = bus64.o_sig_extended;
        g.br = bus64.o_branch_addres; g.jmp = bus64.o_jump_dir;
        cmp_out("d64", g, e);
      end
    end
  end

  initial begin : driver
    stim_t s, r;
    for (int i = 0; i < 32; i++) begin regs32[i] = '0; regs64[i] = '0; end
    rst = 1'b1;

    for (int i = 0; i < 2; i++) begin
      s = rnd_stim(); s.rst = 1'b1; step(s);
    end

    // r5 reads 0 after reset; r4 <- 7 at the same time.
    s = idle(); s.valid = 1; s.instr = rtype(5, 0, 1, 6'h20);
    s.regwrite = 1; s.wb_addr = 4; s.wb_data = 64'd7; step(s);
    // ADD r1,r3,r4 while r3 <- DEADBEEF: 32-bit sees it, 64-bit sees old value.
    s = idle(); s.valid = 1; s.instr = rtype(3, 4, 1, 6'h20);
    s.regwrite = 1; s.wb_addr = 3; s.wb_data = 64'hDEAD_BEEF; step(s);
    s.regwrite = 0; step(s);
    s = idle(); s.valid = 1; s.instr = rtype(0, 3, 2, 6'h20);
    s.regwrite = 1; s.wb_addr = 0; s.wb_data = 64'h1234; step(s);
    s.regwrite = 0; step(s);

    for (int i = 0; i < 6; i++) begin
      s = idle(); s.valid = 1; s.instr = itype(ext_op[i], 1, 2, ext_imm[i]); step(s);
    end
    s = idle(); s.valid = 1; s.pc = 64'h100; s.instr = itype(6'h04, 1, 2, 16'hFFFF); step(s);
    s.pc = 64'h1000_0004; s.instr = {6'h02, 26'h000_0040}; step(s);
    s.pc = 64'hFFFF_FFFF_FFFF_FFFC; s.instr = itype(6'h04, 1, 2, 16'h0001); step(s);

    // Load-use: two consecutive stalls, then release, then non-hazard and rt hazards.
    s = idle(); s.valid = 1; s.memread = 1; s.ex_rt = 8; s.instr = rtype(8, 2, 9, 6'h20);
    step(s); step(s);
    s.memread = 0; step(s);
    s.memread = 1; s.instr = itype(6'h08, 1, 8, 16'h0005); step(s);
    s.instr = rtype(1, 8, 9, 6'h20); step(s);
    s.instr = itype(6'h2B, 1, 8, 16'h0004); step(s);
    s.ex_rt = 0; s.instr = rtype(0, 0, 9, 6'h20); step(s);
    s.ex_rt = 8; s.instr = rtype(8, 2, 9, 6'h20); s.flush = 1; step(s);
    s.flush = 0; s.rst = 1; s.regwrite = 1; s.wb_addr = 6; s.wb_data = 64'h55; step(s);
    s = idle(); s.instr = rtype(3, 4, 1, 6'h20); s.pc = 64'h40; step(s);

    for (int n = 0; n < 600; n++) begin
      r = rnd_stim();
      if (last_stall) begin
        r.instr = s.instr; r.pc = s.pc; r.valid = s.valid;
      end
      s = r;
      step(s);
    end

    s = idle(); step(s); step(s);
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
Parametrised decode stage for the MIPS pipeline; successor to the unregistered decode block. Contains the register file with optional write-through bypass, field extraction and immediate extension, branch/jump target computation, load-use hazard detection with a stall output to IF, and a registered ID/EX boundary with valid, flush and bubble insertion. Sits between the IF/ID register and the execute stage; write-back drives its write port.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64; immediates and targets extend to DATA_W.
RF_BYPASS, 1, 1 = a same-cycle write-back to a read address returns the write data (write-through); 0 = the old value is read.
HAZARD_EN, 1, 1 = load-use detection active; 0 = o_stall tied 0.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
i_instr  in  32  instruction from IF/ID.
i_pc_plus4  in  DATA_W  PC+4 of i_instr.
i_valid  in  1  i_instr is a real instruction.
i_flush  in  1  squash the instruction currently in ID (taken branch/jump).
i_regwrite  in  1  write-back enable.
i_wb_addr  in  5  write-back register.
i_wb_data  in  DATA_W  write-back data.
i_ex_memread  in  1  instruction now in EX is a load.
i_ex_rt_addr  in  5  destination of that load.
o_stall  out  1  hold PC and IF/ID this cycle (combinational).
o_valid  out  1  ID/EX holds a real instruction.
o_op  out  6  opcode.
o_funct  out  6  funct field.
o_shamt  out  5  shift amount.
o_rs_addr, o_rt_addr, o_rd_addr  out  5 each  register addresses.
o_rs_reg, o_rt_reg  out  DATA_W each  register values.
o_sig_extended  out  DATA_W  extended immediate.
o_branch_addres  out  DATA_W  branch target.
o_jump_dir  out  DATA_W  jump target.

Behaviour:
- Reset: in the cycle rst is high, all 32 registers and all ID/EX outputs clear to 0, and o_valid is 0. o_stall is 0 while rst is high. rst has priority over every other input, including mid-stall.
- Register file: 32 x DATA_W. r0 reads 0 and ignores writes. Writes occur on the edge when i_regwrite=1 and i_wb_addr!=0.
- Reads are combinational into the ID/EX register. With RF_BYPASS=1, a matching non-zero i_wb_addr with i_regwrite=1 returns i_wb_data.
- Immediate: opcodes ANDI 0x0C, ORI 0x0D and XORI 0x0E zero-extend. LUI 0x0F gives imm<<16, sign-extended from bit 31 when DATA_W=64. All other opcodes sign-extend imm[15].
- Branch target: i_pc_plus4 + (sext(imm)<<2), modulo 2^DATA_W, wrap-around allowed.
- Jump target: {i_pc_plus4[DATA_W-1:28], instr[25:0], 2'b00}.
- Load-use condition: hazard = HAZARD_EN & i_valid & i_ex_memread & (i_ex_rt_addr!=0) & ((i_ex_rt_addr==rs) | (i_ex_rt_addr==rt & uses_rt)).
  - uses_rt = R-type (op 0), BEQ 0x04, BNE 0x05, or stores 0x28/0x29/0x2B.
- Stall: o_stall = hazard & ~i_flush. While o_stall=1, ID/EX loads a bubble (o_valid=0, all fields 0) and IF/ID holds, so the instruction is re-decoded next cycle. A second consecutive stall is legal.
- Flush: if i_flush=1, ID/EX loads a bubble and o_stall=0. Flush has priority over stall.
- Normal case: ID/EX captures decode results with o_valid=i_valid. Latency is 1 cycle from i_instr to outputs.
- Bubble encoding: all outputs 0, which is equivalent to SLL r0,r0,0.
- Simultaneous write-back and stall: the register file write still happens; only the ID/EX capture is replaced by a bubble.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, OP_SB, OP_SH);
  - REG_ADDR_W=5 and INSTR_W=32;
  - field-slice bit positions.
- One sub-module: id_regfile (32 x DATA_W, two read ports, one write port, r0 zero, RF_BYPASS parameter, synchronous clear on rst).
- Hazard logic and extension logic stay inline.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs -> all outputs 0; after release, reading r5 gives 0.
2. Bypass: write r3=0xDEADBEEF while decoding ADD r1,r3,r4 with r4=7 -> o_rs_reg=0xDEADBEEF next cycle (RF_BYPASS=1); old value with RF_BYPASS=0; a write to r0 leaves reads at 0.
3. Extension: ADDI imm 0xFFFC -> o_sig_extended=0xFFFFFFFC; ORI 0xFFFC -> 0x0000FFFC; LUI 0x1234 -> 0x12340000. BEQ imm -1 at pc+4=0x100 -> branch 0xFC; J target 0x0000040 at pc+4=0x10000004 -> 0x10000100.
4. Load-use: i_ex_memread=1, i_ex_rt_addr=8, instr ADD r9,r8,r2 -> o_stall=1 and a bubble is issued. The same instruction with i_ex_memread=0 -> o_stall=0 and o_valid=1 after 1 cycle. Using ADDI with rt=8 -> no stall.
5. Flush priority: hazard condition plus i_flush=1 -> o_stall=0, o_valid=0 next cycle.
6. DATA_W=64: repeat scenario 3 -> results are sign/zero-extended to 64 bits, and branch wrap from 0xFFFF_FFFF_FFFF_FFFC with imm +1 gives 0x0.
